// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: front end of the stopwatch -- button conditioning, IDLE/RUN/PAUSE control,
//   and the prescaler that paces the cascaded BCD digit chain.
// Latency: raw button rise -> press pulse DEBOUNCE_CYC+3 clk (+1 async sampling); press -> state +1 clk.
// Backpressure: none; tick_o/cnt_clr_o are fire-and-forget single-cycle pulses to the digit chain.
//
// Ports:
//   clk_i      system clock (50 MHz nominal)
//   rst_i      asynchronous reset, active-high
//   btn_go_i   raw start/stop pushbutton, asynchronous to clk_i
//   btn_clr_i  raw clear pushbutton, asynchronous to clk_i
//   tick_o     one-cycle enable for the least-significant digit counter
//   cnt_clr_o  one-cycle synchronous clear for the whole digit chain
//   running_o  high while in RUN
//   paused_o   high while in PAUSE

// stopwatch_debounce: synchronise one raw button, debounce it, emit a one-cycle press pulse.
// Latency: clean raw rise -> press_o high DEBOUNCE_CYC+3 clk later.
// Backpressure: none; a held button yields exactly one pulse, releases yield none.
module stopwatch_debounce #(
    parameter int DEBOUNCE_CYC = 1000000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic press_o
);

    localparam int            CW       = $clog2(DEBOUNCE_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          db_q;
    logic          db_d;
    logic          db_prev_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          press_q;

    // The counter only runs while the synchronised level disagrees with the
    // accepted level; any agreeing cycle restarts the qualification window,
    // so a glitch shorter than DEBOUNCE_CYC cycles never flips db_q.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d = ~db_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            db_q      <= 1'b0;
            cnt_q     <= '0;
            db_prev_q <= 1'b0;
            press_q   <= 1'b0;
        end else begin
            sync1_q   <= btn_i;
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            cnt_q     <= cnt_d;
            db_prev_q <= db_q;
            // Rising edge of the accepted level only; release is silent.
            press_q   <= db_q & ~db_prev_q;
        end
    end

    assign press_o = press_q;

endmodule

module stopwatch_ctrl #(
    parameter int PRESCALE     = 500000,
    parameter int DEBOUNCE_CYC = 1000000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_go_i,
    input  logic btn_clr_i,
    output logic tick_o,
    output logic cnt_clr_o,
    output logic running_o,
    output logic paused_o
);

    localparam int            PW         = $clog2(PRESCALE);
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    logic          go_p;
    logic          clr_p;
    state_t        state_q;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          presc_last;
    logic          cnt_clr_q;
    logic          running_q;
    logic          paused_q;

    stopwatch_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_db_go (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .btn_i   (btn_go_i),
        .press_o (go_p)
    );

    stopwatch_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_db_clr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .btn_i   (btn_clr_i),
        .press_o (clr_p)
    );

    // Prescaler advances only in RUN, so PAUSE freezes it and a resume
    // continues the partially elapsed tick period rather than restarting it.
    always_comb begin
        presc_last = (presc_q == PRESC_LAST);
        presc_d    = presc_q;
        if (state_q == ST_RUN) begin
            presc_d = presc_last ? '0 : presc_q + PW'(1);
        end
    end

    // The prescaler step is taken before the state decision, so a go press on
    // the terminal RUN cycle still lets that cycle's tick count and the wrap to
    // 0 is what PAUSE holds. Clear is evaluated first so it beats a
    // simultaneous go press.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            cnt_clr_q <= 1'b0;
            running_q <= 1'b0;
            paused_q  <= 1'b0;
        end else begin
            cnt_clr_q <= 1'b0;
            presc_q   <= presc_d;
            if (clr_p) begin
                state_q   <= ST_IDLE;
                presc_q   <= '0;
                cnt_clr_q <= 1'b1;
                running_q <= 1'b0;
                paused_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (go_p) begin
                            state_q   <= ST_RUN;
                            presc_q   <= '0;
                            running_q <= 1'b1;
                            paused_q  <= 1'b0;
                        end
                    end
                    ST_RUN: begin
                        if (go_p) begin
                            state_q   <= ST_PAUSE;
                            running_q <= 1'b0;
                            paused_q  <= 1'b1;
                        end
                    end
                    ST_PAUSE: begin
                        if (go_p) begin
                            state_q   <= ST_RUN;
                            running_q <= 1'b1;
                            paused_q  <= 1'b0;
                        end
                    end
                    default: begin
                        // Unused encoding: fall back to a clean IDLE.
                        state_q   <= ST_IDLE;
                        presc_q   <= '0;
                        running_q <= 1'b0;
                        paused_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tick_o    = (state_q == ST_RUN) && presc_last;
    assign cnt_clr_o = cnt_clr_q;
    assign running_o = running_q;
    assign paused_o  = paused_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;

    localparam int PRESCALE = 4;
    localparam int DB       = 3;
    // Raw button set after edge P -> state/cnt_clr visible after edge P+LAT.
    localparam int LAT      = DB + 4;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b10;
    localparam logic [1:0] S_PAUSE = 2'b01;

    localparam int EV_ST   = 0;
    localparam int EV_CLR  = 1;
    localparam int EV_TICK = 2;

    typedef struct {
        int         kind;
        int         at;
        logic [1:0] val;
    } ev_t;

    logic clk     = 1'b0;
    logic rst     = 1'b1;
    logic btn_go  = 1'b0;
    logic btn_clr = 1'b0;
    logic tick;
    logic cnt_clr;
    logic running;
    logic paused;

    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    ev_t  exp_q[$];

    stopwatch_ctrl #(
        .PRESCALE     (PRESCALE),
        .DEBOUNCE_CYC (DB)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .btn_go_i  (btn_go),
        .btn_clr_i (btn_clr),
        .tick_o    (tick),
        .cnt_clr_o (cnt_clr),
        .running_o (running),
        .paused_o  (paused)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string ev_name(input int k);
        case (k)
            EV_ST:   return "state";
            EV_CLR:  return "cnt_clr";
            default: return "tick";
        endcase
    endfunction

    task automatic expect_ev(input int kind, input int at, input logic [1:0] val);
        ev_t e;
        e.kind = kind;
        e.at   = at;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    // Ticks while RUN spans cycles [r, stop) with prescaler value s at cycle r.
    task automatic expect_ticks(input int r, input int s, input int stop);
        for (int c = r; c < stop; c++) begin
            if ((c - r + s) % PRESCALE == PRESCALE - 1) expect_ev(EV_TICK, c, 2'b00);
        end
    endtask

    task automatic chk(input string name, input logic act, input logic want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %b want %b (cyc %0d)", name, act, want, cyc);
        end
    endtask

    task automatic check_ev(input int kind, input logic [1:0] val);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected %s: got val=%b at cyc %0d, want no event", ev_name(kind), val, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.at != cyc || e.val != val) begin
                bad++;
                $display("FAIL event: got %s@%0d val=%b, want %s@%0d val=%b",
                         ev_name(kind), cyc, val, ev_name(e.kind), e.at, e.val);
            end
        end
    endtask

    // Observes outputs away from the active edge and matches each event against the queue.
    task automatic monitor();
        logic [1:0] prev_st;
        logic [1:0] st;
        prev_st = S_IDLE;
        forever begin
            @(negedge clk);
            st = {running, paused};
            total++;
            if (st == 2'b11) begin
                bad++;
                $display("FAIL excl: running=1 paused=1 at cyc %0d, want at most one high", cyc);
            end
            if (st != prev_st) check_ev(EV_ST, st);
            if (cnt_clr) check_ev(EV_CLR, 2'b00);
            if (tick) check_ev(EV_TICK, 2'b00);
            prev_st = st;
        end
    endtask

    task automatic watchdog();
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: still running at cyc %0d, want done before 20000", cyc);
        $fatal(1, "timeout");
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic press(input logic go, input logic clr, input int hold);
        btn_go  = go;
        btn_clr = clr;
        repeat (hold) @(negedge clk);
        btn_go  = 1'b0;
        btn_clr = 1'b0;
    endtask

    initial begin
        int p;
        int r;
        int rr;

        fork
            monitor();
            watchdog();
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tick", tick, 1'b0);
        chk("rst_cnt_clr", cnt_clr, 1'b0);
        chk("rst_running", running, 1'b0);
        chk("rst_paused", paused, 1'b0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // Start with a 10-cycle hold; pause timed so the held prescaler is 2
        p = cyc + 2;
        r = p + LAT;
        expect_ev(EV_ST, r, S_RUN);
        expect_ticks(r, 0, r + 26);
        expect_ev(EV_ST, r + 26, S_PAUSE);
        wait_cyc(p);
        press(1'b1, 1'b0, 10);
        wait_cyc(r + 19);
        press(1'b1, 1'b0, 3);
        wait_cyc(r + 30);
        chk("pause_paused", paused, 1'b1);
        chk("pause_running", running, 1'b0);

        // Resume after >50 paused cycles, 2-cycle glitch in RUN, clear from RUN
        p  = r + 26 + 50;
        rr = p + LAT;
        expect_ev(EV_ST, rr, S_RUN);
        expect_ticks(rr, 2, rr + 32);
        expect_ev(EV_ST, rr + 32, S_IDLE);
        expect_ev(EV_CLR, rr + 32, 2'b00);
        wait_cyc(p);
        press(1'b1, 1'b0, 4);
        wait_cyc(rr + 10);
        press(1'b1, 1'b0, 2);
        wait_cyc(rr + 25);
        press(1'b0, 1'b1, 4);
        wait_cyc(rr + 33);
        chk("clr_running", running, 1'b0);
        chk("clr_pulse_len", cnt_clr, 1'b0);

        // Fresh start from IDLE, pause, then clear from PAUSE
        p = rr + 45;
        r = p + LAT;
        expect_ev(EV_ST, r, S_RUN);
        expect_ticks(r, 0, r + 15);
        expect_ev(EV_ST, r + 15, S_PAUSE);
        expect_ev(EV_ST, r + 35, S_IDLE);
        expect_ev(EV_CLR, r + 35, 2'b00);
        wait_cyc(p);
        press(1'b1, 1'b0, 4);
        wait_cyc(r + 8);
        press(1'b1, 1'b0, 4);
        wait_cyc(r + 28);
        press(1'b0, 1'b1, 4);

        // Go and clear debounced together from IDLE: clear wins, no RUN
        p = r + 55;
        expect_ev(EV_CLR, p + LAT, 2'b00);
        wait_cyc(p);
        press(1'b1, 1'b1, 4);

        // Go on the terminal prescaler cycle: tick that cycle, then PAUSE at 0
        p = p + 25;
        r = p + LAT;
        expect_ev(EV_ST, r, S_RUN);
        expect_ticks(r, 0, r + 16);
        expect_ev(EV_ST, r + 16, S_PAUSE);
        // Resume proves the held prescaler is 0; clear on the terminal cycle
        rr = r + 29 + LAT;
        expect_ev(EV_ST, rr, S_RUN);
        expect_ticks(rr, 0, rr + 16);
        expect_ev(EV_ST, rr + 16, S_IDLE);
        expect_ev(EV_CLR, rr + 16, 2'b00);
        wait_cyc(p);
        press(1'b1, 1'b0, 4);
        wait_cyc(r + 9);
        press(1'b1, 1'b0, 4);
        wait_cyc(r + 29);
        press(1'b1, 1'b0, 4);
        wait_cyc(rr + 9);
        press(1'b0, 1'b1, 4);

        // Async reset in the middle of a tick
        p = rr + 35;
        r = p + LAT;
        expect_ev(EV_ST, r, S_RUN);
        expect_ticks(r, 0, r + 4);
        expect_ev(EV_ST, r + 4, S_IDLE);
        wait_cyc(p);
        press(1'b1, 1'b0, 4);
        wait_cyc(r + 3);
        chk("pre_rst_running", running, 1'b1);
        chk("pre_rst_tick", tick, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_tick", tick, 1'b0);
        chk("async_rst_cnt_clr", cnt_clr, 1'b0);
        chk("async_rst_running", running, 1'b0);
        chk("async_rst_paused", paused, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (25) @(negedge clk);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover: %0d expected events never seen, first %s@%0d, want 0",
                     exp_q.size(), ev_name(exp_q[0].kind), exp_q[0].at);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
